conv_feed_sequencer: RTL

Parametrised address generator and stream sequencer that feeds the convolution core. For each (kernel, channel) plane it reads one K×K weight kernel and then sweeps the input feature map as K-row bands of column pairs, emitting one LANES-wide beat per cycle. Plane order is kernel-major, channel-minor. It replaces fixed-size stimulus sequencing with configurable geometry, valid/ready backpressure and a synchronous-read SRAM interface.

---
 rtl/conv_feed_sequencer_if.sv | 15 +
 rtl/conv_feed_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_feed_sequencer_if.sv
// Output beat stream of the convolution feed sequencer: LANES-wide data with
// weight/last tags and valid/ready flow control.
interface conv_feed_sequencer_if #(
  parameter int DW    = 8,
  parameter int LANES = 8
);
  logic [LANES*DW-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_is_wgt;
  logic                out_last;

  modport master (output out_data, out_valid, out_is_wgt, out_last, input out_ready);
  modport slave  (input out_data, out_valid, out_is_wgt, out_last, output out_ready);
endinterface

// File: rtl/conv_feed_sequencer.sv
// Address generator/stream sequencer: per (kernel, channel) plane reads one KxK
// weight kernel, then sweeps the fmap as K-row bands of column pairs.
module conv_feed_sequencer #(
  parameter int DW     = 8,
  parameter int K      = 4,
  parameter int FMAP_W = 64,
  parameter int FMAP_H = 64,
  parameter int LANES  = 2*K,
  parameter int WA_W   = 16,
  parameter int FA_W   = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_start_conv,
  input  logic [2:0]            in_cfg_ci,
  input  logic [2:0]            in_cfg_co,
  output logic [WA_W-1:0]       wgt_raddr,
  output logic                  wgt_ren,
  input  logic [LANES*DW-1:0]   wgt_rdata,
  output logic [K*FA_W-1:0]     fmap_raddr,
  output logic                  fmap_ren,
  input  logic [K*2*DW-1:0]     fmap_rdata,
  conv_feed_sequencer_if.master out_if,
  output logic                  out_busy,
  output logic                  out_end_conv
);
  localparam int CW = 16;
  localparam logic [CW-1:0] LAST_B = CW'(K/2 - 1);
  localparam logic [CW-1:0] LAST_C = CW'(FMAP_W/2 - 1);
  localparam logic [CW-1:0] LAST_R = CW'(FMAP_H - K);
  localparam logic [31:0]   HK     = 32'(K/2);
  localparam logic [31:0]   NC     = 32'(FMAP_W/2);
  localparam logic [31:0]   FH     = 32'(FMAP_H);

  typedef enum logic [2:0] {S_IDLE, S_WGT, S_FMAP, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [LANES*DW-1:0] data;
    logic                is_wgt;
    logic                last;
  } entry_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   b_q, b_d, r_q, r_d, c_q, c_d, p_q, p_d;
  logic [4:0]      ci_q, ci_d, co_q, co_d, ci_max_q, ci_max_d, co_max_q, co_max_d;
  logic            inflight_q, inflight_d, tag_wgt_q, tag_wgt_d, tag_last_q, tag_last_d;
  entry_t          fifo_q [2];
  entry_t          fifo_d [2];
  logic            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;

  entry_t          in_entry, head;
  logic            valid, pop, fifo_push, fifo_pop, can_issue;
  logic [2:0]      occ;
  logic [31:0]     p32;

  function automatic logic [4:0] cfg_max(input logic [2:0] v);
    return {(v > 3'd3) ? 2'd3 : v[1:0], 3'b111};
  endfunction

  // Output stage: an empty FIFO forwards returning read data straight to the
  // consumer; anything not taken that cycle is captured for later.
  always_comb begin
    in_entry.is_wgt = tag_wgt_q;
    in_entry.last   = tag_last_q;
    in_entry.data   = wgt_rdata;
    if (!tag_wgt_q) begin
      for (int unsigned i = 0; i < K; i++) begin
        in_entry.data[i*DW +: DW]     = fmap_rdata[(2*i)*DW +: DW];
        in_entry.data[(K+i)*DW +: DW] = fmap_rdata[(2*i+1)*DW +: DW];
      end
    end
    head      = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : in_entry;
    valid     = (count_q != 2'd0) || inflight_q;
    pop       = valid && out_if.out_ready;
    fifo_pop  = pop && (count_q != 2'd0);
    fifo_push = inflight_q && !(pop && (count_q == 2'd0));
    fifo_d    = fifo_q;
    if (fifo_push) fifo_d[wr_ptr_q] = in_entry;
    wr_ptr_d  = wr_ptr_q ^ fifo_push;
    rd_ptr_d  = rd_ptr_q ^ fifo_pop;
    count_d   = count_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
    occ       = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    can_issue = (occ <= 3'd1);

    out_if.out_valid  = valid;
    out_if.out_data   = valid ? head.data   : '0;
    out_if.out_is_wgt = valid ? head.is_wgt : 1'b0;
    out_if.out_last   = valid ? head.last   : 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    r_d      = r_q;
    c_d      = c_q;
    p_d      = p_q;
    ci_d     = ci_q;
    co_d     = co_q;
    ci_max_d = ci_max_q;
    co_max_d = co_max_q;
    wgt_ren  = 1'b0;
    fmap_ren = 1'b0;
    tag_last_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_start_conv) begin
          state_d  = S_WGT;
          ci_max_d = cfg_max(in_cfg_ci);
          co_max_d = cfg_max(in_cfg_co);
          b_d = '0; r_d = '0; c_d = '0; p_d = '0; ci_d = '0; co_d = '0;
        end
      end
      S_WGT: begin
        if (can_issue) begin
          wgt_ren = 1'b1;
          if (b_q == LAST_B) begin
            b_d     = '0;
            state_d = S_FMAP;
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end
      S_FMAP: begin
        if (can_issue) begin
          fmap_ren   = 1'b1;
          tag_last_d = (r_q == LAST_R) && (c_q == LAST_C);
          if (c_q != LAST_C) begin
            c_d = c_q + 1'b1;
          end else begin
            c_d = '0;
            if (r_q != LAST_R) begin
              r_d = r_q + 1'b1;
            end else begin
              r_d = '0;
              p_d = p_q + 1'b1;
              if (ci_q != ci_max_q) begin
                ci_d    = ci_q + 1'b1;
                state_d = S_WGT;
              end else if (co_q != co_max_q) begin
                ci_d    = '0;
                co_d    = co_q + 1'b1;
                state_d = S_WGT;
              end else begin
                state_d = S_DRAIN;
              end
            end
          end
        end
      end
      S_DRAIN: if (count_d == 2'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    inflight_d   = wgt_ren | fmap_ren;
    tag_wgt_d    = wgt_ren;
    out_busy     = (state_q == S_WGT) || (state_q == S_FMAP) || (state_q == S_DRAIN);
    out_end_conv = (state_q == S_DONE);
  end

  always_comb begin
    p32        = 32'(p_q);
    wgt_raddr  = wgt_ren ? WA_W'(p32 * HK + 32'(b_q)) : '0;
    fmap_raddr = '0;
    if (fmap_ren) begin
      for (int unsigned i = 0; i < K; i++)
        fmap_raddr[i*FA_W +: FA_W] = FA_W'((p32 * FH + 32'(r_q) + 32'(i)) * NC + 32'(c_q));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      b_q        <= '0;
      r_q        <= '0;
      c_q        <= '0;
      p_q        <= '0;
      ci_q       <= '0;
      co_q       <= '0;
      ci_max_q   <= '0;
      co_max_q   <= '0;
      inflight_q <= 1'b0;
      tag_wgt_q  <= 1'b0;
      tag_last_q <= 1'b0;
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      b_q        <= b_d;
      r_q        <= r_d;
      c_q        <= c_d;
      p_q        <= p_d;
      ci_q       <= ci_d;
      co_q       <= co_d;
      ci_max_q   <= ci_max_d;
      co_max_q   <= co_max_d;
      inflight_q <= inflight_d;
      tag_wgt_q  <= tag_wgt_d;
      tag_last_q <= tag_last_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end
endmodule
